// File: rtl/csi2_pkg.sv
// Shared types, constants and the CRC-16 byte update for the CSI-2 lane packet framer.
package csi2_pkg;

    localparam logic [7:0]  SYNC_BYTE    = 8'hB8;
    localparam logic [5:0]  SHORT_DT_MAX = 6'h0F;
    // x^16+x^12+x^5+1 in reflected (LSB-first) form
    localparam logic [15:0] CRC_POLY     = 16'h8408;
    localparam logic [15:0] CRC_INIT     = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_HDR  = 3'd2,
        ST_PLD  = 3'd3,
        ST_CRC  = 3'd4
    } state_t;

    typedef struct packed {
        logic [1:0]  vc;
        logic [5:0]  dt;
        logic [15:0] wc;
    } hdr_t;

    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ data[i]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/csi2_hdr_ecc.sv
// Combinational CSI-2 header Hamming parity: 24 data bits {WC_MSB, WC_LSB, DI} to 6 ECC bits.
module csi2_hdr_ecc (
    input  logic [23:0] data,
    output logic [5:0]  ecc
);

    localparam logic [23:0] MASK_P0 = 24'hF12CB7;
    localparam logic [23:0] MASK_P1 = 24'hF2555B;
    localparam logic [23:0] MASK_P2 = 24'h749A6D;
    localparam logic [23:0] MASK_P3 = 24'hB8E38E;
    localparam logic [23:0] MASK_P4 = 24'hDF03F0;
    localparam logic [23:0] MASK_P5 = 24'hEFFC00;

    assign ecc = {^(data & MASK_P5), ^(data & MASK_P4), ^(data & MASK_P3),
                  ^(data & MASK_P2), ^(data & MASK_P1), ^(data & MASK_P0)};

endmodule

// File: rtl/csi2_pkt_framer.sv
// Per-lane CSI-2 packet framer: sync hunt, header ECC check, payload forwarding and CRC-16 check.
module csi2_pkt_framer
    import csi2_pkg::*;
#(
    parameter logic [15:0] MAX_WC = 16'hFFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        wait_for_sync_o,
    output logic        packet_done_o,
    output logic        hdr_valid_o,
    output logic [1:0]  hdr_vc_o,
    output logic [5:0]  hdr_dt_o,
    output logic [15:0] hdr_wc_o,
    output logic        pld_valid_o,
    output logic [7:0]  pld_data_o,
    output logic        pld_sop_o,
    output logic        pld_eop_o,
    output logic        crc_valid_o,
    output logic        crc_err_o,
    output logic        hdr_err_o
);

    state_t      state_r, state_n;
    logic [1:0]  hdr_cnt_r, hdr_cnt_n;
    logic [23:0] hdr_bytes_r, hdr_bytes_n;
    logic [15:0] rem_r, rem_n;
    logic        sop_pend_r, sop_pend_n;
    logic [15:0] crc_r, crc_n;
    logic [7:0]  crc_lo_r, crc_lo_n;
    logic        crc_cnt_r, crc_cnt_n;
    hdr_t        hdr_r, hdr_n;
    logic        wait_r, wait_n, done_r, done_n;
    logic        hdr_valid_r, hdr_valid_n, hdr_err_r, hdr_err_n;
    logic        pld_valid_r, pld_valid_n, sop_r, sop_n, eop_r, eop_n;
    logic [7:0]  pld_data_r, pld_data_n;
    logic        crc_valid_r, crc_valid_n, crc_err_r, crc_err_n;
    logic [5:0]  ecc_calc_s, syndrome_s;
    logic [7:0]  di_s;
    logic [15:0] wc_s;

    // Header bytes are complete by the time the ECC byte arrives, so parity runs on the stored copy
    csi2_hdr_ecc u_ecc (
        .data (hdr_bytes_r),
        .ecc  (ecc_calc_s)
    );

    assign di_s       = hdr_bytes_r[7:0];
    assign wc_s       = hdr_bytes_r[23:8];
    assign syndrome_s = ecc_calc_s ^ byte_i[5:0];

    // Next-state and next-output decode
    always_comb begin
        state_n     = state_r;
        hdr_cnt_n   = hdr_cnt_r;
        hdr_bytes_n = hdr_bytes_r;
        rem_n       = rem_r;
        sop_pend_n  = sop_pend_r;
        crc_n       = crc_r;
        crc_lo_n    = crc_lo_r;
        crc_cnt_n   = crc_cnt_r;
        hdr_n       = hdr_r;
        done_n      = 1'b0;
        hdr_valid_n = 1'b0;
        hdr_err_n   = 1'b0;
        pld_valid_n = 1'b0;
        pld_data_n  = pld_data_r;
        sop_n       = 1'b0;
        eop_n       = 1'b0;
        crc_valid_n = 1'b0;
        crc_err_n   = crc_err_r;
        if (!enable_i) begin
            state_n    = ST_IDLE;
            hdr_cnt_n  = 2'd0;
            rem_n      = 16'd0;
            sop_pend_n = 1'b0;
            crc_cnt_n  = 1'b0;
            done_n     = (state_r == ST_HDR) || (state_r == ST_PLD) || (state_r == ST_CRC);
        end else begin
            case (state_r)
                ST_IDLE: state_n = ST_SYNC;
                ST_SYNC: begin
                    if (byte_valid_i && (byte_i == SYNC_BYTE)) begin
                        state_n   = ST_HDR;
                        hdr_cnt_n = 2'd0;
                    end else begin
                        state_n = ST_SYNC;
                    end
                end
                ST_HDR: begin
                    if (!byte_valid_i) begin
                        state_n = ST_HDR;
                    end else if (hdr_cnt_r != 2'd3) begin
                        case (hdr_cnt_r)
                            2'd0:    hdr_bytes_n[7:0]   = byte_i;
                            2'd1:    hdr_bytes_n[15:8]  = byte_i;
                            default: hdr_bytes_n[23:16] = byte_i;
                        endcase
                        hdr_cnt_n = hdr_cnt_r + 2'd1;
                    end else begin
                        hdr_cnt_n = 2'd0;
                        if ((syndrome_s != 6'd0) || ({1'b0, wc_s} > {1'b0, MAX_WC})) begin
                            hdr_err_n = 1'b1;
                            done_n    = 1'b1;
                            state_n   = ST_SYNC;
                        end else begin
                            hdr_valid_n = 1'b1;
                            hdr_n       = '{vc: di_s[7:6], dt: di_s[5:0], wc: wc_s};
                            crc_n       = CRC_INIT;
                            crc_cnt_n   = 1'b0;
                            if (di_s[5:0] <= SHORT_DT_MAX) begin
                                done_n  = 1'b1;
                                state_n = ST_SYNC;
                            end else if (wc_s == 16'd0) begin
                                state_n = ST_CRC;
                            end else begin
                                state_n    = ST_PLD;
                                rem_n      = wc_s;
                                sop_pend_n = 1'b1;
                            end
                        end
                    end
                end
                ST_PLD: begin
                    if (byte_valid_i) begin
                        pld_valid_n = 1'b1;
                        pld_data_n  = byte_i;
                        sop_n       = sop_pend_r;
                        sop_pend_n  = 1'b0;
                        crc_n       = crc16_byte(crc_r, byte_i);
                        rem_n       = rem_r - 16'd1;
                        if (rem_r == 16'd1) begin
                            eop_n   = 1'b1;
                            state_n = ST_CRC;
                        end else begin
                            state_n = ST_PLD;
                        end
                    end else begin
                        state_n = ST_PLD;
                    end
                end
                ST_CRC: begin
                    if (!byte_valid_i) begin
                        state_n = ST_CRC;
                    end else if (!crc_cnt_r) begin
                        crc_lo_n  = byte_i;
                        crc_cnt_n = 1'b1;
                    end else begin
                        crc_valid_n = 1'b1;
                        crc_err_n   = ({byte_i, crc_lo_r} != crc_r);
                        done_n      = 1'b1;
                        crc_cnt_n   = 1'b0;
                        state_n     = ST_SYNC;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
        wait_n = (state_n == ST_IDLE) || (state_n == ST_SYNC);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            hdr_cnt_r   <= 2'd0;
            hdr_bytes_r <= 24'd0;
            rem_r       <= 16'd0;
            sop_pend_r  <= 1'b0;
            crc_r       <= CRC_INIT;
            crc_lo_r    <= 8'd0;
            crc_cnt_r   <= 1'b0;
            hdr_r       <= '0;
            wait_r      <= 1'b1;
            done_r      <= 1'b0;
            hdr_valid_r <= 1'b0;
            hdr_err_r   <= 1'b0;
            pld_valid_r <= 1'b0;
            pld_data_r  <= 8'd0;
            sop_r       <= 1'b0;
            eop_r       <= 1'b0;
            crc_valid_r <= 1'b0;
            crc_err_r   <= 1'b0;
        end else begin
            state_r     <= state_n;
            hdr_cnt_r   <= hdr_cnt_n;
            hdr_bytes_r <= hdr_bytes_n;
            rem_r       <= rem_n;
            sop_pend_r  <= sop_pend_n;
            crc_r       <= crc_n;
            crc_lo_r    <= crc_lo_n;
            crc_cnt_r   <= crc_cnt_n;
            hdr_r       <= hdr_n;
            wait_r      <= wait_n;
            done_r      <= done_n;
            hdr_valid_r <= hdr_valid_n;
            hdr_err_r   <= hdr_err_n;
            pld_valid_r <= pld_valid_n;
            pld_data_r  <= pld_data_n;
            sop_r       <= sop_n;
            eop_r       <= eop_n;
            crc_valid_r <= crc_valid_n;
            crc_err_r   <= crc_err_n;
        end
    end

    assign wait_for_sync_o = wait_r;
    assign packet_done_o   = done_r;
    assign hdr_valid_o     = hdr_valid_r;
    assign hdr_vc_o        = hdr_r.vc;
    assign hdr_dt_o        = hdr_r.dt;
    assign hdr_wc_o        = hdr_r.wc;
    assign hdr_err_o       = hdr_err_r;
    assign pld_valid_o     = pld_valid_r;
    assign pld_data_o      = pld_data_r;
    assign pld_sop_o       = sop_r;
    assign pld_eop_o       = eop_r;
    assign crc_valid_o     = crc_valid_r;
    assign crc_err_o       = crc_err_r;

endmodule

// File: tb/tb_csi2_pkt_framer.sv
// Directed self-checking bench for csi2_pkt_framer.
module tb_csi2_pkt_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        bvalid;
    logic [7:0]  bdata;
    logic        wait_sync, done, hdr_valid, pld_valid, sop, eop, crc_valid, crc_err, hdr_err;
    logic [1:0]  vc;
    logic [5:0]  dt;
    logic [15:0] wc;
    logic [7:0]  pdata;

    int n_cmp = 0;
    int n_err = 0;

    csi2_pkt_framer #(.MAX_WC(16'hFFFF)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .enable_i        (enable),
        .byte_valid_i    (bvalid),
        .byte_i          (bdata),
        .wait_for_sync_o (wait_sync),
        .packet_done_o   (done),
        .hdr_valid_o     (hdr_valid),
        .hdr_vc_o        (vc),
        .hdr_dt_o        (dt),
        .hdr_wc_o        (wc),
        .pld_valid_o     (pld_valid),
        .pld_data_o      (pdata),
        .pld_sop_o       (sop),
        .pld_eop_o       (eop),
        .crc_valid_o     (crc_valid),
        .crc_err_o       (crc_err),
        .hdr_err_o       (hdr_err)
    );

    always #5 clk = ~clk;

    // Present one byte slot, then look at the outputs it caused just after the edge.
    task automatic drive(input logic v, input logic [7:0] d);
        bvalid = v;
        bdata  = d;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {8'h00, d};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1;
        drive(1'b0, 8'h00);
        drive(1'b1, 8'hB8);
        n_cmp++;
        if ({wait_sync, done, hdr_valid, hdr_err, pld_valid, sop, eop, crc_valid, crc_err} !== 9'b1_0000_0000) begin
            n_err++; $display("FAIL reset_flags: got %b want 100000000",
                {wait_sync, done, hdr_valid, hdr_err, pld_valid, sop, eop, crc_valid, crc_err});
        end
        n_cmp++;
        if ({vc, dt, wc, pdata} !== 32'd0) begin
            n_err++; $display("FAIL reset_fields: got %h want 0", {vc, dt, wc, pdata});
        end
        rst = 1'b0;
        drive(1'b0, 8'h00);
        n_cmp++;
        if ({wait_sync, done} !== 2'b10) begin
            n_err++; $display("FAIL reset_release: got %b want 10", {wait_sync, done});
        end
    endtask

    task automatic test_short();
        drive(1'b1, 8'hB8);
        n_cmp++;
        if (wait_sync !== 1'b0) begin n_err++; $display("FAIL short_sync: wait got %b want 0", wait_sync); end
        drive(1'b1, 8'h00); drive(1'b1, 8'h00); drive(1'b1, 8'h00); drive(1'b1, 8'h00);
        n_cmp++;
        if ({hdr_valid, done, hdr_err, pld_valid, wait_sync} !== 5'b11001) begin
            n_err++; $display("FAIL short_ecc: got %b want 11001", {hdr_valid, done, hdr_err, pld_valid, wait_sync});
        end
        n_cmp++;
        if ({vc, dt, wc} !== 24'd0) begin n_err++; $display("FAIL short_fields: got %h want 0", {vc, dt, wc}); end
        drive(1'b0, 8'h00);
        n_cmp++;
        if ({hdr_valid, done, pld_valid} !== 3'b000) begin
            n_err++; $display("FAIL short_after: got %b want 000", {hdr_valid, done, pld_valid});
        end
    endtask

    task automatic test_long_packet(input logic [7:0] p2, input logic gapped, input string tag);
        logic [7:0]  hb [5];
        logic [7:0]  tx [4];
        logic [7:0]  pl [4];
        logic [15:0] crc;
        hb = '{8'hB8, 8'h2A, 8'h04, 8'h00, 8'h33};
        tx = '{8'h11, 8'h22, 8'h33, 8'h44};
        pl = tx;
        pl[2] = p2;
        crc = 16'hFFFF;
        for (int i = 0; i < 4; i++) crc = crc_step(crc, tx[i]);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, hb[i]);
            n_cmp++;
            if (i < 4) begin
                if ({wait_sync, hdr_valid, done} !== 3'b000) begin
                    n_err++; $display("FAIL %s_hdr%0d: got %b want 000", tag, i, {wait_sync, hdr_valid, done});
                end
            end else if ({hdr_valid, hdr_err, done, wait_sync, vc, dt, wc} !== {4'b1000, 2'd0, 6'h2A, 16'h0004}) begin
                n_err++; $display("FAIL %s_hdr_ok: got %b %h want 1000 002a0004", tag,
                    {hdr_valid, hdr_err, done, wait_sync}, {vc, dt, wc});
            end
            if (gapped) begin
                drive(1'b0, 8'hB8);
                n_cmp++;
                if ({hdr_valid, pld_valid, done, wait_sync} !== 4'b0000) begin
                    n_err++; $display("FAIL %s_hgap%0d: got %b want 0000", tag, i, {hdr_valid, pld_valid, done, wait_sync});
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, pl[i]);
            n_cmp++;
            if ({pld_valid, sop, eop, pdata} !== {1'b1, (i == 0), (i == 3), pl[i]}) begin
                n_err++; $display("FAIL %s_pld%0d: got v/s/e %b data %h want %b data %h", tag, i,
                    {pld_valid, sop, eop}, pdata, {1'b1, (i == 0), (i == 3)}, pl[i]);
            end
            if (gapped) begin
                drive(1'b0, 8'h00);
                n_cmp++;
                if ({pld_valid, sop, eop} !== 3'b000) begin
                    n_err++; $display("FAIL %s_pgap%0d: got %b want 000", tag, i, {pld_valid, sop, eop});
                end
            end
        end
        drive(1'b1, crc[7:0]);
        n_cmp++;
        if ({crc_valid, done, pld_valid} !== 3'b000) begin
            n_err++; $display("FAIL %s_crc_lo: got %b want 000", tag, {crc_valid, done, pld_valid});
        end
        if (gapped) drive(1'b0, 8'h00);
        drive(1'b1, crc[15:8]);
        n_cmp++;
        if ({crc_valid, crc_err, done, wait_sync} !== {1'b1, (p2 != 8'h33), 1'b1, 1'b1}) begin
            n_err++; $display("FAIL %s_crc: got %b want %b", tag, {crc_valid, crc_err, done, wait_sync},
                {1'b1, (p2 != 8'h33), 1'b1, 1'b1});
        end
        drive(1'b0, 8'h00);
        n_cmp++;
        if ({crc_valid, done} !== 2'b00) begin
            n_err++; $display("FAIL %s_crc_after: got %b want 00", tag, {crc_valid, done});
        end
    endtask

    task automatic test_bad_ecc();
        logic [7:0] hb [5];
        hb = '{8'hB8, 8'h2A, 8'h04, 8'h00, 8'h32};
        for (int i = 0; i < 5; i++) drive(1'b1, hb[i]);
        n_cmp++;
        if ({hdr_err, done, hdr_valid, wait_sync} !== 4'b1101) begin
            n_err++; $display("FAIL badecc_pulse: got %b want 1101", {hdr_err, done, hdr_valid, wait_sync});
        end
        n_cmp++;
        if ({vc, dt, wc} !== {2'd0, 6'h2A, 16'h0004}) begin
            n_err++; $display("FAIL badecc_hold: got %h want 002a0004", {vc, dt, wc});
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h11 * (i + 1));
            n_cmp++;
            if ({pld_valid, hdr_err, hdr_valid, wait_sync} !== 4'b0001) begin
                n_err++; $display("FAIL badecc_nopld%0d: got %b want 0001", i, {pld_valid, hdr_err, hdr_valid, wait_sync});
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] seq [7];
        seq = '{8'hB8, 8'h2A, 8'h04, 8'h00, 8'h33, 8'h11, 8'h22};
        for (int i = 0; i < 7; i++) drive(1'b1, seq[i]);
        n_cmp++;
        if ({pld_valid, pdata, wait_sync} !== {1'b1, 8'h22, 1'b0}) begin
            n_err++; $display("FAIL abort_pld2: got %b %h %b want 1 22 0", pld_valid, pdata, wait_sync);
        end
        enable = 1'b0;
        drive(1'b0, 8'h00);
        n_cmp++;
        if ({done, eop, pld_valid, wait_sync} !== 4'b1001) begin
            n_err++; $display("FAIL abort_done: got %b want 1001", {done, eop, pld_valid, wait_sync});
        end
        drive(1'b0, 8'h00);
        n_cmp++;
        if ({done, wait_sync} !== 2'b01) begin
            n_err++; $display("FAIL abort_once: got %b want 01", {done, wait_sync});
        end
        enable = 1'b1;
        drive(1'b0, 8'h00);
        n_cmp++;
        if ({done, wait_sync} !== 2'b01) begin
            n_err++; $display("FAIL abort_reenable: got %b want 01", {done, wait_sync});
        end
    endtask

    task automatic test_sync_hunt();
        logic [7:0]  junk [3];
        logic [7:0]  sh [5];
        logic [7:0]  lh [4];
        logic [15:0] crc;
        junk = '{8'h00, 8'hFF, 8'hA5};
        sh   = '{8'hB8, 8'h41, 8'h00, 8'h00, 8'h11};
        lh   = '{8'h2A, 8'h04, 8'h00, 8'h33};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, junk[i]);
            n_cmp++;
            if ({wait_sync, hdr_valid, hdr_err} !== 3'b100) begin
                n_err++; $display("FAIL hunt_junk%0d: got %b want 100", i, {wait_sync, hdr_valid, hdr_err});
            end
        end
        for (int i = 0; i < 5; i++) drive(1'b1, sh[i]);
        n_cmp++;
        if ({hdr_valid, done, wait_sync, vc, dt, wc} !== {3'b111, 2'd1, 6'h01, 16'h0000}) begin
            n_err++; $display("FAIL hunt_short: got %b %h want 111 410000", {hdr_valid, done, wait_sync}, {vc, dt, wc});
        end
        drive(1'b1, 8'hB8);
        n_cmp++;
        if ({wait_sync, done} !== 2'b00) begin
            n_err++; $display("FAIL b2b_sync: got %b want 00", {wait_sync, done});
        end
        for (int i = 0; i < 4; i++) drive(1'b1, lh[i]);
        n_cmp++;
        if ({hdr_valid, dt, wc} !== {1'b1, 6'h2A, 16'h0004}) begin
            n_err++; $display("FAIL b2b_hdr: got %b %h %h want 1 2a 0004", hdr_valid, dt, wc);
        end
        crc = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h11 * (i + 1));
            crc = crc_step(crc, 8'h11 * (i + 1));
        end
        drive(1'b1, crc[7:0]);
        drive(1'b1, crc[15:8]);
        n_cmp++;
        if ({crc_valid, crc_err, done} !== 3'b101) begin
            n_err++; $display("FAIL b2b_crc: got %b want 101", {crc_valid, crc_err, done});
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; bvalid = 1'b0; bdata = 8'h00;
        test_reset();
        test_short();
        test_long_packet(8'h33, 1'b0, "long");
        test_long_packet(8'h32, 1'b0, "corrupt");
        test_bad_ecc();
        test_long_packet(8'h33, 1'b1, "gapped");
        test_abort();
        test_sync_hunt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: run did not finish, want finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
